// File: rtl/wddl_pkg.sv
// Shared types and default parameters for the WDDL dual-rail front/back end.
// Imported by the stage controller and the rail checker.
package wddl_pkg;

  localparam int unsigned WDDL_WIDTH       = 8;
  localparam int unsigned WDDL_EVAL_CYCLES = 2;
  localparam int unsigned WDDL_PRE_CYCLES  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    PRECH = 2'd2
  } wddl_state_e;

  // Counter must hold the larger of the two window lengths minus one.
  function automatic int unsigned cnt_width(input int unsigned eval_cycles,
                                            input int unsigned pre_cycles);
    int unsigned max_cycles;
    max_cycles = (eval_cycles > pre_cycles) ? eval_cycles : pre_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/wddl_rail_check.sv
// Combinational health check of a dual-rail result bus: flags any pair that
// is not complementary, and any rail that is high (used during precharge).
module wddl_rail_check #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] res_t,
  input  logic [WIDTH-1:0] res_f,
  output logic             pair_err,
  output logic             not_zero
);

  assign pair_err = |(~(res_t ^ res_f));
  assign not_zero = |(res_t | res_f);

endmodule

// File: rtl/wddl_dual_rail_stage.sv
// Drives single-rail words into a WDDL network as precharged dual-rail pairs,
// samples the result after a fixed evaluate window and returns it downstream.
module wddl_dual_rail_stage
  import wddl_pkg::*;
#(
  parameter int unsigned WIDTH       = WDDL_WIDTH,
  parameter int unsigned EVAL_CYCLES = WDDL_EVAL_CYCLES,
  parameter int unsigned PRE_CYCLES  = WDDL_PRE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] rail_t,
  output logic [WIDTH-1:0] rail_f,
  output logic             prech,
  input  logic [WIDTH-1:0] res_t,
  input  logic [WIDTH-1:0] res_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             pre_err
);

  localparam int unsigned    CW        = cnt_width(EVAL_CYCLES, PRE_CYCLES);
  localparam logic [CW-1:0]  EVAL_LOAD = CW'(EVAL_CYCLES - 1);
  localparam logic [CW-1:0]  PRE_LOAD  = CW'(PRE_CYCLES - 1);

  wddl_state_e      r_state;
  wddl_state_e      w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rail_t;
  logic [WIDTH-1:0] r_rail_f;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;
  logic             r_pre_err;

  logic             w_accept;
  logic             w_cnt_done;
  logic             w_sample;
  logic             w_prech_end;
  logic             w_pair_err;
  logic             w_not_zero;

  wddl_rail_check #(.WIDTH(WIDTH)) u_rail_check (
    .res_t    (res_t),
    .res_f    (res_f),
    .pair_err (w_pair_err),
    .not_zero (w_not_zero)
  );

  assign w_accept    = in_valid && in_ready;
  assign w_cnt_done  = (r_cnt == '0);
  assign w_sample    = (r_state == EVAL)  && w_cnt_done;
  assign w_prech_end = (r_state == PRECH) && w_cnt_done;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first means no path leaves w_state_nxt
  // unassigned, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)   w_state_nxt = EVAL;
      EVAL:    if (w_cnt_done) w_state_nxt = PRECH;
      PRECH:   if (w_cnt_done) w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
  end

  // A pending result blocks new words: there is no second result register.
  always_comb begin
    in_ready = (r_state == IDLE) && !r_out_valid;
    prech    = (r_state != EVAL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rail_t <= '0;
      r_rail_f <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt    <= EVAL_LOAD;
            r_rail_t <= in_data;
            r_rail_f <= ~in_data;
          end
        end
        EVAL: begin
          if (w_cnt_done) begin
            r_cnt    <= PRE_LOAD;
            r_rail_t <= '0;
            r_rail_f <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        PRECH: begin
          if (!w_cnt_done) r_cnt <= r_cnt - CW'(1);
        end
        default: begin
          r_cnt    <= '0;
          r_rail_t <= '0;
          r_rail_f <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_pre_err   <= 1'b0;
    end else begin
      if (w_sample) begin
        r_out_valid <= 1'b1;
        r_out_data  <= res_t;
        r_out_err   <= w_pair_err;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      // Sticky until reset: a network that fails to precharge leaks data.
      if (w_prech_end && w_not_zero) r_pre_err <= 1'b1;
    end
  end

  assign rail_t    = r_rail_t;
  assign rail_f    = r_rail_f;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign pre_err   = r_pre_err;

endmodule

// File: tb/tb_wddl_dual_rail_stage.sv
// Self-checking bench for wddl_dual_rail_stage: table vectors, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_wddl_dual_rail_stage;

  localparam int unsigned W    = 8;
  localparam int unsigned EVAL = 2;
  localparam int unsigned PRE  = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] rail_t, rail_f;
  logic         prech;
  logic [W-1:0] res_t, res_f;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_err;
  logic         pre_err;

  // Network model controls
  logic [W-1:0] key;
  logic         ovr;
  logic [W-1:0] ovr_t, ovr_f;
  logic [W-1:0] stuck_t, stuck_f;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  wddl_dual_rail_stage #(.WIDTH(W), .EVAL_CYCLES(EVAL), .PRE_CYCLES(PRE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rail_t    (rail_t),
    .rail_f    (rail_f),
    .prech     (prech),
    .res_t     (res_t),
    .res_f     (res_f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .pre_err   (pre_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural WDDL network: zero out when precharged, XOR-with-key otherwise.
  always_comb begin
    res_t = stuck_t;
    res_f = stuck_f;
    if ((rail_t | rail_f) != '0) begin
      if (ovr) begin
        res_t = ovr_t;
        res_f = ovr_f;
      end else begin
        res_t = rail_t ^ key;
        res_f = rail_f ^ key;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level scoreboard / protocol monitor ----------
  typedef struct {
    logic [W-1:0] d;
    logic         e;
  } exp_t;

  exp_t         sb_q[$];
  int           last_acc = 0;
  bit           have_acc = 0;
  bit           prev_ov  = 0;
  bit           prev_nz  = 0;
  logic [W-1:0] prev_t   = '0;
  int           run      = 0;

  function automatic exp_t predict(input logic [W-1:0] d);
    exp_t r;
    logic [W-1:0] t, f;
    t = ovr ? ovr_t : (d ^ key);
    f = ovr ? ovr_f : ~(d ^ key);
    r.d = t;
    r.e = 1'b0;
    for (int i = 0; i < int'(W); i++) if (t[i] == f[i]) r.e = 1'b1;
    return r;
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] exp_f;
    bit           nz;
    if (!rst_n) begin
      sb_q.delete();
      have_acc = 0;
      prev_ov  = 0;
      prev_nz  = 0;
      run      = 0;
    end else begin
      nz = ((rail_t | rail_f) != '0);
      check("prech_vs_rails", prech, !nz);
      if (nz) begin
        exp_f = ~rail_t;
        check("rail_complement", rail_f, exp_f);
        if (prev_nz) check("rail_hold", rail_t, prev_t);
        run++;
        check("eval_window_len", run <= int'(EVAL), 1);
      end else begin
        run = 0;
      end
      prev_nz = nz;
      prev_t  = rail_t;

      if (out_valid) begin
        check("ready_while_valid", in_ready, 0);
        if (!prev_ov) check("latency", cyc, last_acc + int'(EVAL));
        if (sb_q.size() == 0) begin
          check("spurious_valid", out_valid, 0);
        end else begin
          check("sb_data", out_data, sb_q[0].d);
          check("sb_err", out_err, sb_q[0].e);
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      prev_ov = out_valid;

      if (in_valid && in_ready) begin
        if (have_acc) check("accept_gap", (cyc + 1 - last_acc) >= int'(EVAL + PRE + 1), 1);
        sb_q.push_back(predict(in_data));
        last_acc = cyc + 1;
        have_acc = 1;
      end
    end
  end

  // ---------------- driver tasks ---------------------------------------------
  task automatic send(input logic [W-1:0] d);
    int n = 0;
    @(posedge clk); #1;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_accepted", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [W-1:0] d, output logic e);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("result_arrived", out_valid, 1);
    d = out_data;
    e = out_err;
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic         ovr;
    logic [W-1:0] ot;
    logic [W-1:0] of;
    logic [W-1:0] exp_d;
    logic         exp_e;
  } vec_t;

  vec_t         tbl[8];
  logic [W-1:0] got_d;
  logic         got_e;
  int           acc[16];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 8'h00, 8'h00, 8'hAA, 1'b0};
    tbl[1] = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h0F, 1'b0};
    tbl[2] = '{8'hFF, 1'b0, 8'h00, 8'h00, 8'hF0, 1'b0};
    tbl[3] = '{8'h3C, 1'b0, 8'h00, 8'h00, 8'h33, 1'b0};
    tbl[4] = '{8'h5A, 1'b1, 8'h01, 8'h01, 8'h01, 1'b1};
    tbl[5] = '{8'hC3, 1'b1, 8'h00, 8'hFF, 8'h00, 1'b0};
    tbl[6] = '{8'h11, 1'b1, 8'hF0, 8'h0F, 8'hF0, 1'b0};
    tbl[7] = '{8'h22, 1'b1, 8'h80, 8'h00, 8'h80, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    key = 8'h0F; ovr = 1'b0; ovr_t = '0; ovr_f = '0; stuck_t = '0; stuck_f = '0;
    #1;
    check("rst_rail_t", rail_t, 0);
    check("rst_rail_f", rail_f, 0);
    check("rst_prech", prech, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_pre_err", pre_err, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // Table vectors: normal function and faulty-network patterns
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      ovr = tbl[i].ovr; ovr_t = tbl[i].ot; ovr_f = tbl[i].of;
      send(tbl[i].din);
      wait_result(got_d, got_e);
      check($sformatf("vec%0d_data", i), got_d, tbl[i].exp_d);
      check($sformatf("vec%0d_err", i), got_e, tbl[i].exp_e);
    end
    @(posedge clk); #1 ovr = 1'b0;
    check("pre_err_clean", pre_err, 0);

    // Backpressure: result held, input blocked until consumed
    out_ready = 1'b0;
    send(8'h21);
    wait_result(got_d, got_e);
    check("bp_first", got_d, 8'h2E);
    @(posedge clk); #1;
    in_data = 8'h44; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_data", out_data, 8'h2E);
      check("bp_hold_valid", out_valid, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    begin
      int p;
      p = cyc + 1;
      @(negedge clk);
      check("bp_ready_after", in_ready, 1);
      @(posedge clk); #1 in_valid = 1'b0;
      check("bp_accept_edge", last_acc, p + 1);
    end
    wait_result(got_d, got_e);
    check("bp_second", got_d, 8'h4B);

    // Network stuck high during precharge: sticky pre_err
    @(posedge clk); #1 stuck_t = 8'h80;
    send(8'h10);
    wait_result(got_d, got_e);
    check("stuck_data", got_d, 8'h1F);
    repeat (2) @(negedge clk);
    check("pre_err_set", pre_err, 1);
    @(posedge clk); #1 stuck_t = 8'h00;
    for (int i = 0; i < 2; i++) begin
      send(8'h70 + 8'(i));
      wait_result(got_d, got_e);
      check("clean_after_stuck", got_d, 8'h7F - 8'(i));
      check("pre_err_sticky", pre_err, 1);
    end
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check("pre_err_reset", pre_err, 0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Reset pulse in the middle of an evaluate window
    send(8'h3C);
    @(negedge clk);
    check("mid_rail_t", rail_t, 8'h3C);
    check("mid_rail_f", rail_f, 8'hC3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rail_t", rail_t, 0);
    check("async_rail_f", rail_f, 0);
    check("async_prech", prech, 1);
    @(negedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_valid_after_rst", out_valid, 0);
    end
    send(8'h66);
    wait_result(got_d, got_e);
    check("post_rst_data", got_d, 8'h69);

    // Back-to-back stream of 16 words
    begin
      int k = 0;
      int n = 0;
      @(posedge clk); #1;
      out_ready = 1'b1; in_data = 8'($urandom); in_valid = 1'b1;
      while (k < 16 && n < 300) begin
        @(negedge clk);
        n++;
        if (in_ready) begin
          acc[k] = cyc + 1;
          k++;
          @(posedge clk); #1;
          if (k < 16) in_data = 8'($urandom);
          else        in_valid = 1'b0;
        end
      end
      in_valid = 1'b0;
      check("b2b_count", k, 16);
      for (int i = 1; i < k; i++) check("b2b_gap", acc[i] - acc[i-1], EVAL + PRE + 1);
      repeat (8) @(negedge clk);
      check("b2b_drained", sb_q.size(), 0);
    end

    // Randomized traffic with random backpressure and key
    @(posedge clk); #1 key = 8'($urandom);
    for (int w = 0; w < 40; w++) begin
      bit done = 0;
      int n = 0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(8'($urandom));
      while (!done && n < 200) begin
        @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (out_valid && out_ready) done = 1;
        n++;
      end
      check("rand_consumed", done, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("rand_drained", sb_q.size(), 0);
    check("pre_err_final", pre_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
